power_iteration_ctrl: RTL and testbench

Sequencing controller for the eigenvector power-iteration loop of the fetal ECG separation datapath. It drives, in order, the matrix-vector multiply, vector normalisation, and convergence-check sub-blocks, and judges the Frobenius norm of the vector difference against a tolerance. It either commits the new vector and loops, or terminates with converged or timeout status.
Children use the codebase start/f handshake: start is held high until f is seen.

---
 rtl/power_iteration_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_power_iteration_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/power_iteration_ctrl.sv
// power_iteration_ctrl
//   Sequencer for the eigenvector power-iteration loop. One iteration runs the
//   matrix-vector multiply, the normaliser and the convergence check in turn,
//   then judges the returned Frobenius norm against the tolerance. The loop
//   either commits the new vector and repeats, or stops with converged or
//   timeout status.
//
// Child handshake (the same for all three children): the controller raises
//   <child>_start and holds it until <child>_f is sampled high. In the next
//   cycle <child>_start is low (a release cycle). The next child is started
//   only after that cycle, so consecutive starts always have at least one idle
//   cycle between them. At most one child start is high at any time.
//
// Optional build macro: PIC_STALL_WATCHDOG_EN adds a per-stage watchdog. If a
//   child does not answer within STALL_CYCLES cycles, the run ends in DONE
//   with stall_err=1. Without the macro, stall_err is tied low and waits are
//   unbounded.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   start             level request; dropping it aborts a busy run
//   tol               IEEE-754 double tolerance, latched on IDLE->MULT
//   conv_norm         IEEE-754 double norm, valid while chk_f is high
//   mult_start/mult_f matrix-vector multiply handshake
//   nrm_start/nrm_f   normaliser handshake
//   chk_start/chk_f   convergence-check handshake
//   vec_load          one-cycle pulse: commit next_vector
//   iter_count        completed iterations, saturating at MAX_ITER
//   f                 run finished; held until start drops
//   converged/timeout final status, valid while f=1
//   stall_err         watchdog abort status
//   state_dbg         current FSM state encoding, for observation
module power_iteration_ctrl #(
  parameter int unsigned MAX_ITER     = 64,
  parameter int unsigned ITER_W       = 8,
  parameter int unsigned STALL_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [63:0]       tol,
  input  logic [63:0]       conv_norm,
  output logic              mult_start,
  input  logic              mult_f,
  output logic              nrm_start,
  input  logic              nrm_f,
  output logic              chk_start,
  input  logic              chk_f,
  output logic              vec_load,
  output logic [ITER_W-1:0] iter_count,
  output logic              f,
  output logic              converged,
  output logic              timeout,
  output logic              stall_err,
  output logic [2:0]        state_dbg
);

  if (MAX_ITER < 1) begin : g_bad_max_iter
    $error("power_iteration_ctrl: MAX_ITER must be at least 1");
  end
  if (MAX_ITER >= (64'd1 << ITER_W)) begin : g_bad_iter_w
    $error("power_iteration_ctrl: ITER_W too narrow for MAX_ITER");
  end
  if (STALL_CYCLES < 1) begin : g_bad_stall
    $error("power_iteration_ctrl: STALL_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MULT   = 3'd1,
    S_NRM    = 3'd2,
    S_CHK    = 3'd3,
    S_DECIDE = 3'd4,
    S_UPDATE = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  localparam logic [ITER_W:0] MAX_EXT = (ITER_W+1)'(MAX_ITER);

  state_e            state_q, state_d;
  logic              rel_q, rel_d;        // child released, waiting one idle cycle
  logic [62:0]       tol_q, tol_d;        // sign of tol is not needed: tol is positive
  logic [63:0]       norm_q, norm_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              mult_start_q, mult_start_d;
  logic              nrm_start_q, nrm_start_d;
  logic              chk_start_q, chk_start_d;
  logic              vec_load_q, vec_load_d;
  logic              f_q, f_d;
  logic              conv_q, conv_d;
  logic              tmo_q, tmo_d;

`ifdef PIC_STALL_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(STALL_CYCLES + 1) + 1;
  // The stall fires at the edge that ends the STALL_CYCLES-th waiting cycle.
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(STALL_CYCLES - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            stall_q, stall_d;
`endif

  logic unused_tol_sign;
  assign unused_tol_sign = tol[63];

  logic busy;
  logic cur_f;
  logic norm_nan;
  logic pass;
  logic [ITER_W:0] iter_next;

  assign busy = (state_q == S_MULT) || (state_q == S_NRM) || (state_q == S_CHK) ||
                (state_q == S_DECIDE) || (state_q == S_UPDATE);

  always_comb begin
    cur_f = 1'b0;
    case (state_q)
      S_MULT:  cur_f = mult_f;
      S_NRM:   cur_f = nrm_f;
      S_CHK:   cur_f = chk_f;
      default: cur_f = 1'b0;
    endcase
  end

  // For non-negative doubles the magnitude bits order like an unsigned
  // integer, so the compare needs no floating-point hardware. -0.0 and NaN
  // are rejected explicitly.
  assign norm_nan  = (norm_q[62:52] == 11'h7FF) && (norm_q[51:0] != 52'd0);
  assign pass      = !norm_q[63] && !norm_nan && (norm_q[62:0] <= tol_q);
  assign iter_next = {1'b0, iter_q} + (ITER_W+1)'(1);

  always_comb begin
    state_d      = state_q;
    rel_d        = rel_q;
    tol_d        = tol_q;
    norm_d       = norm_q;
    iter_d       = iter_q;
    mult_start_d = mult_start_q;
    nrm_start_d  = nrm_start_q;
    chk_start_d  = chk_start_q;
    vec_load_d   = 1'b0;
    f_d          = f_q;
    conv_d       = conv_q;
    tmo_d        = tmo_q;
`ifdef PIC_STALL_WATCHDOG_EN
    wd_d         = wd_q;
    stall_d      = stall_q;
`endif

    if (busy && !start) begin
      // Abort: release every child and go idle. iter_count keeps its value.
      state_d      = S_IDLE;
      rel_d        = 1'b0;
      mult_start_d = 1'b0;
      nrm_start_d  = 1'b0;
      chk_start_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            tol_d        = tol[62:0];
            iter_d       = '0;
            conv_d       = 1'b0;
            tmo_d        = 1'b0;
            rel_d        = 1'b0;
            mult_start_d = 1'b1;
            state_d      = S_MULT;
`ifdef PIC_STALL_WATCHDOG_EN
            stall_d      = 1'b0;
            wd_d         = '0;
`endif
          end
        end

        S_MULT, S_NRM, S_CHK: begin
          if (!rel_q) begin
            if (cur_f) begin
              mult_start_d = 1'b0;
              nrm_start_d  = 1'b0;
              chk_start_d  = 1'b0;
              rel_d        = 1'b1;
              if (state_q == S_CHK) norm_d = conv_norm;
            end
`ifdef PIC_STALL_WATCHDOG_EN
            else if (wd_q == WD_LIMIT) begin
              mult_start_d = 1'b0;
              nrm_start_d  = 1'b0;
              chk_start_d  = 1'b0;
              stall_d      = 1'b1;
              conv_d       = 1'b0;
              tmo_d        = 1'b0;
              f_d          = 1'b1;
              state_d      = S_DONE;
            end else begin
              wd_d = wd_q + WD_W'(1);
            end
`endif
          end else begin
            // Release cycle is over: start the next child or go judge.
            rel_d = 1'b0;
`ifdef PIC_STALL_WATCHDOG_EN
            wd_d  = '0;
`endif
            case (state_q)
              S_MULT: begin
                state_d     = S_NRM;
                nrm_start_d = 1'b1;
              end
              S_NRM: begin
                state_d     = S_CHK;
                chk_start_d = 1'b1;
              end
              default: state_d = S_DECIDE;
            endcase
          end
        end

        S_DECIDE: begin
          if (pass) conv_d = 1'b1;
          else if (iter_next == MAX_EXT) tmo_d = 1'b1;
          if ({1'b0, iter_q} < MAX_EXT) iter_d = iter_next[ITER_W-1:0];
          vec_load_d = 1'b1;
          state_d    = S_UPDATE;
        end

        S_UPDATE: begin
          if (conv_q || tmo_q) begin
            f_d     = 1'b1;
            state_d = S_DONE;
          end else begin
            mult_start_d = 1'b1;
            state_d      = S_MULT;
`ifdef PIC_STALL_WATCHDOG_EN
            wd_d         = '0;
`endif
          end
        end

        S_DONE: begin
          if (!start) begin
            f_d     = 1'b0;
            state_d = S_IDLE;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rel_q        <= 1'b0;
      tol_q        <= '0;
      norm_q       <= '0;
      iter_q       <= '0;
      mult_start_q <= 1'b0;
      nrm_start_q  <= 1'b0;
      chk_start_q  <= 1'b0;
      vec_load_q   <= 1'b0;
      f_q          <= 1'b0;
      conv_q       <= 1'b0;
      tmo_q        <= 1'b0;
`ifdef PIC_STALL_WATCHDOG_EN
      wd_q         <= '0;
      stall_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rel_q        <= rel_d;
      tol_q        <= tol_d;
      norm_q       <= norm_d;
      iter_q       <= iter_d;
      mult_start_q <= mult_start_d;
      nrm_start_q  <= nrm_start_d;
      chk_start_q  <= chk_start_d;
      vec_load_q   <= vec_load_d;
      f_q          <= f_d;
      conv_q       <= conv_d;
      tmo_q        <= tmo_d;
`ifdef PIC_STALL_WATCHDOG_EN
      wd_q         <= wd_d;
      stall_q      <= stall_d;
`endif
    end
  end

  assign mult_start = mult_start_q;
  assign nrm_start  = nrm_start_q;
  assign chk_start  = chk_start_q;
  assign vec_load   = vec_load_q;
  assign iter_count = iter_q;
  assign f          = f_q;
  assign converged  = conv_q;
  assign timeout    = tmo_q;
  assign state_dbg  = state_q;
`ifdef PIC_STALL_WATCHDOG_EN
  assign stall_err  = stall_q;
`else
  assign stall_err  = 1'b0;
`endif

endmodule

// File: tb/tb_power_iteration_ctrl.sv
// Bench for power_iteration_ctrl (MAX_ITER=5, STALL_CYCLES=16).
// Handshake seen by children: start is held until f is sampled; f is a
// one-cycle pulse from the responders below, with random 1..3 cycle latency.
module tb_power_iteration_ctrl;

  localparam int MAX_ITER = 5;
  localparam int ITER_W   = 8;
  localparam int RES_W    = 3 + ITER_W;

  logic              clk, rst, start;
  logic [63:0]       tol, conv_norm;
  logic              mult_start, mult_f, nrm_start, nrm_f, chk_start, chk_f;
  logic              vec_load, f, converged, timeout, stall_err;
  logic [ITER_W-1:0] iter_count;
  logic [2:0]        state_dbg;

  power_iteration_ctrl #(.MAX_ITER(MAX_ITER), .ITER_W(ITER_W), .STALL_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .start(start), .tol(tol), .conv_norm(conv_norm),
    .mult_start(mult_start), .mult_f(mult_f),
    .nrm_start(nrm_start), .nrm_f(nrm_f),
    .chk_start(chk_start), .chk_f(chk_f),
    .vec_load(vec_load), .iter_count(iter_count), .f(f),
    .converged(converged), .timeout(timeout), .stall_err(stall_err),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared bench state ----------------
  logic [RES_W-1:0] exp_q[$];
  logic [63:0]      norm_tab[$];
  int               run_id;
  bit               mult_hang;
  int               n_cmp, n_fail;
  int               mult_rises, nrm_rises, chk_rises, vec_loads;

  localparam logic [63:0] TOL_1EM6 = 64'h3EB0C6F7A0B5ED8D;
  localparam logic [63:0] HALF     = 64'h3FE0000000000000;
  localparam logic [63:0] TWO      = 64'h4000000000000000;
  localparam logic [63:0] QNAN     = 64'h7FF8000000000000;
  localparam logic [63:0] NEG_ZERO = 64'h8000000000000000;
  localparam logic [63:0] POS_ZERO = 64'h0000000000000000;

  // ---------------- child responders ----------------
  initial begin : mult_child
    int cnt, lat;
    mult_f = 1'b0; cnt = 0; lat = 1;
    forever begin
      @(posedge clk); #1;
      if (mult_f) mult_f = 1'b0;
      else if (mult_start && !mult_hang) begin
        cnt++;
        if (cnt >= lat) begin mult_f = 1'b1; cnt = 0; lat = $urandom_range(1, 3); end
      end else cnt = 0;
    end
  end

  initial begin : nrm_child
    int cnt, lat;
    nrm_f = 1'b0; cnt = 0; lat = 2;
    forever begin
      @(posedge clk); #1;
      if (nrm_f) nrm_f = 1'b0;
      else if (nrm_start) begin
        cnt++;
        if (cnt >= lat) begin nrm_f = 1'b1; cnt = 0; lat = $urandom_range(1, 3); end
      end else cnt = 0;
    end
  end

  initial begin : chk_child
    int cnt, lat, idx, seen_run;
    chk_f = 1'b0; conv_norm = '0; cnt = 0; lat = 1; idx = 0; seen_run = -1;
    forever begin
      @(posedge clk); #1;
      if (seen_run != run_id) begin seen_run = run_id; idx = 0; end
      if (chk_f) begin
        chk_f = 1'b0;
        conv_norm = 64'hDEAD_BEEF_DEAD_BEEF;
      end else if (chk_start) begin
        cnt++;
        if (cnt >= lat && norm_tab.size() > 0) begin
          conv_norm = (idx < norm_tab.size()) ? norm_tab[idx] : norm_tab[norm_tab.size()-1];
          idx++;
          chk_f = 1'b1; cnt = 0; lat = $urandom_range(1, 3);
        end
      end else cnt = 0;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decision using real-number comparison.
  function automatic bit model_pass(input logic [63:0] n, input logic [63:0] t);
    if (n[63]) return 1'b0;
    if (n[62:52] == 11'h7FF && n[51:0] != 52'd0) return 1'b0;
    return $bitstoreal(n) <= $bitstoreal(t);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_case(input string tag, input logic [63:0] t);
    int iters, m0, n0, c0, v0;
    bit conv, tmo, seen;
    logic [63:0] n;
    iters = 0; conv = 0; tmo = 0;
    while (!conv && !tmo) begin
      n = (iters < norm_tab.size()) ? norm_tab[iters] : norm_tab[norm_tab.size()-1];
      iters++;
      if (model_pass(n, t)) conv = 1;
      else if (iters == MAX_ITER) tmo = 1;
    end
    exp_q.push_back({conv, tmo, 1'b0, ITER_W'(iters)});
    m0 = mult_rises; n0 = nrm_rises; c0 = chk_rises; v0 = vec_loads;
    run_id++;
    tol = t;
    start = 1'b1;
    seen = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (f) begin seen = 1; break; end
    end
    check({tag, "_f_seen"}, 64'(seen), 64'd1);
    if (!seen) exp_q.delete();
    check({tag, "_vec_loads"}, 64'(vec_loads - v0), 64'(iters));
    check({tag, "_mult_starts"}, 64'(mult_rises - m0), 64'(iters));
    check({tag, "_nrm_starts"}, 64'(nrm_rises - n0), 64'(iters));
    check({tag, "_chk_starts"}, 64'(chk_rises - c0), 64'(iters));
    @(negedge clk);
    check({tag, "_f_held"}, 64'(f), 64'(seen));
    start = 1'b0;
    @(negedge clk);
    check({tag, "_f_clear"}, 64'(f), 64'd0);
    check({tag, "_idle"}, 64'(state_dbg), 64'd0);
  endtask

  task automatic wait_for(input string tag, input int which, input int min_loads, input int v0);
    bit ok;
    ok = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if ((vec_loads - v0) >= min_loads &&
          ((which == 1 && mult_start) || (which == 2 && nrm_start) || (which == 3 && chk_start))) begin
        ok = 1; break;
      end
    end
    check({tag, "_reached"}, 64'(ok), 64'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int v0, cyc;
    bit prev_mf, prev_nf, prev_cf, prev_any, prev_f;
    bit prev_m, prev_n, prev_c;
    n_cmp = 0; n_fail = 0; run_id = 0; mult_hang = 0;
    mult_rises = 0; nrm_rises = 0; chk_rises = 0; vec_loads = 0;
    prev_mf = 0; prev_nf = 0; prev_cf = 0; prev_any = 0; prev_f = 0;
    prev_m = 0; prev_n = 0; prev_c = 0;
    rst = 1'b1; start = 1'b0; tol = '0;
    norm_tab = '{HALF};

    // Monitor: protocol checks, event counts, scoreboard pop on f rising.
    fork
      forever begin
        @(negedge clk);
        check("onehot_starts", 64'($onehot0({mult_start, nrm_start, chk_start})), 64'd1);
        if (prev_mf) check("mult_release", 64'(mult_start), 64'd0);
        if (prev_nf) check("nrm_release", 64'(nrm_start), 64'd0);
        if (prev_cf) check("chk_release", 64'(chk_start), 64'd0);
        if ((mult_start && !prev_m) || (nrm_start && !prev_n) || (chk_start && !prev_c))
          check("idle_gap_before_start", 64'(prev_any), 64'd0);
        if (mult_start && !prev_m) mult_rises++;
        if (nrm_start && !prev_n) nrm_rises++;
        if (chk_start && !prev_c) chk_rises++;
        if (vec_load) vec_loads++;
        if (f && !prev_f && !rst) begin
          if (exp_q.size() == 0) check("unexpected_f", 64'(f), 64'd0);
          else check("result", 64'({converged, timeout, stall_err, iter_count}),
                     64'(exp_q.pop_front()));
        end
        prev_mf = mult_f; prev_nf = nrm_f; prev_cf = chk_f;
        prev_m = mult_start; prev_n = nrm_start; prev_c = chk_start;
        prev_any = mult_start | nrm_start | chk_start;
        prev_f = f;
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_f", 64'(f), 64'd0);
    check("rst_iter", 64'(iter_count), 64'd0);
    check("rst_starts", 64'({mult_start, nrm_start, chk_start}), 64'd0);
    check("rst_status", 64'({converged, timeout, stall_err, vec_load}), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);

    // Convergence on the first check
    norm_tab = '{$realtobits(1.0e-7)};
    run_case("conv_first", TOL_1EM6);

    // Three failing iterations, then convergence
    norm_tab = '{HALF, HALF, HALF, $realtobits(1.0e-7)};
    run_case("conv_fourth", TOL_1EM6);

    // Never converges: timeout at MAX_ITER
    norm_tab = '{TWO};
    run_case("timeout", TOL_1EM6);

    // Boundaries of the compare
    norm_tab = '{TOL_1EM6};
    run_case("equal_tol", TOL_1EM6);
    norm_tab = '{TOL_1EM6 + 64'd1, TOL_1EM6};
    run_case("one_ulp_above", TOL_1EM6);
    norm_tab = '{QNAN};
    run_case("nan", TOL_1EM6);
    norm_tab = '{NEG_ZERO};
    run_case("neg_zero", TOL_1EM6);
    norm_tab = '{POS_ZERO};
    run_case("pos_zero", TOL_1EM6);

    // Abort while the normaliser runs in the second iteration
    norm_tab = '{HALF};
    run_id++;
    v0 = vec_loads;
    tol = TOL_1EM6;
    start = 1'b1;
    wait_for("abort_nrm", 2, 1, v0);
    start = 1'b0;
    @(negedge clk);
    check("abort_nrm_start", 64'(nrm_start), 64'd0);
    check("abort_state", 64'(state_dbg), 64'd0);
    check("abort_iter_hold", 64'(iter_count), 64'd1);
    check("abort_no_vec_load", 64'(vec_load), 64'd0);
    repeat (3) @(negedge clk);
    check("abort_vec_loads", 64'(vec_loads - v0), 64'd1);
    check("abort_f", 64'(f), 64'd0);

    // Reset while the convergence check runs in the second iteration
    run_id++;
    v0 = vec_loads;
    start = 1'b1;
    wait_for("rst_chk", 3, 1, v0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_chk_outputs",
          64'({mult_start, nrm_start, chk_start, vec_load, f, converged, timeout, stall_err, iter_count}),
          64'd0);
    check("rst_chk_state", 64'(state_dbg), 64'd0);
    start = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);

`ifdef PIC_STALL_WATCHDOG_EN
    // Multiplier never answers: watchdog ends the run after 16 cycles
    mult_hang = 1;
    run_id++;
    exp_q.push_back({1'b0, 1'b0, 1'b1, ITER_W'(0)});
    start = 1'b1;
    wait_for("wd", 1, 0, vec_loads);
    cyc = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      cyc++;
      if (f) break;
    end
    check("wd_latency", 64'(cyc), 64'd16);
    check("wd_flags", 64'({f, stall_err, converged, timeout, mult_start}), 64'b11000);
    start = 1'b0;
    mult_hang = 0;
    @(negedge clk);
    check("wd_f_clear", 64'(f), 64'd0);
`else
    cyc = 0;
`endif

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
